// File: rtl/mm_pkg.sv
// Shared definitions for the 2x2 signed int8 matrix-multiply operand path:
// frame layout, result width and the launch sequencer states.
package mm_pkg;

  localparam int MM_ELEMS = 8;
  localparam int MM_RES_W = 17;

  // Byte position of each element within a frame (A row-major, then B row-major)
  localparam int IDX_A11 = 0;
  localparam int IDX_A12 = 1;
  localparam int IDX_A21 = 2;
  localparam int IDX_A22 = 3;
  localparam int IDX_B11 = 4;
  localparam int IDX_B12 = 5;
  localparam int IDX_B21 = 6;
  localparam int IDX_B22 = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } mm_state_e;

endpackage

// File: rtl/mm_operand_loader_if.sv
// Byte-serial operand stream with valid/ready handshake and end-of-frame marker.
interface mm_operand_loader_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);

endinterface

// File: rtl/mm_operand_shadow.sv
// Shadow buffer: collects one 8-byte frame, checks framing and holds the frame
// (full) until the sequencer copies it out and pulses clr.
module mm_operand_shadow
  import mm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  input  logic                             clr,
  output logic                             full,
  output logic                             frame_err,
  output logic [MM_ELEMS-1:0][DATA_W-1:0]  shadow_data
);

  localparam int IDX_W = $clog2(MM_ELEMS);

  logic [IDX_W-1:0]                idx_q, idx_d;
  logic                            full_q, full_d;
  logic                            frame_err_q, frame_err_d;
  logic [MM_ELEMS-1:0][DATA_W-1:0] buf_q, buf_d;
  logic                            accept;
  logic                            at_last;

  assign in_ready = !full_q;
  assign accept   = in_valid && !full_q;
  assign at_last  = (idx_q == IDX_W'(MM_ELEMS - 1));

  genvar gi;
  generate
    for (gi = 0; gi < MM_ELEMS; gi = gi + 1) begin : g_buf
      assign buf_d[gi] = (accept && (idx_q == IDX_W'(gi))) ? in_data : buf_q[gi];
    end
  endgenerate

  always_comb begin
    idx_d       = idx_q;
    full_d      = full_q;
    frame_err_d = frame_err_q;
    if (clr) begin
      full_d = 1'b0;
    end
    if (accept) begin
      // in_last must coincide exactly with the final slot; anything else drops the frame
      if (in_last != at_last) begin
        idx_d       = '0;
        frame_err_d = 1'b1;
      end else if (at_last) begin
        idx_d  = '0;
        full_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      full_q      <= 1'b0;
      frame_err_q <= 1'b0;
      buf_q       <= '0;
    end else begin
      idx_q       <= idx_d;
      full_q      <= full_d;
      frame_err_q <= frame_err_d;
      buf_q       <= buf_d;
    end
  end

  assign full        = full_q;
  assign frame_err   = frame_err_q;
  assign shadow_data = buf_q;

endmodule

// File: rtl/mm_operand_loader.sv
// Operand loader for the 2x2 systolic multiplier: latches a completed shadow
// frame into stable operand registers, runs the array and strobes res_valid.
module mm_operand_loader
  import mm_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int RUN_CYCLES = 7
) (
  input  logic              clk,
  input  logic              rst,
  mm_operand_loader_if.slave s_if,
  output logic [DATA_W-1:0] a11,
  output logic [DATA_W-1:0] a12,
  output logic [DATA_W-1:0] a21,
  output logic [DATA_W-1:0] a22,
  output logic [DATA_W-1:0] b11,
  output logic [DATA_W-1:0] b12,
  output logic [DATA_W-1:0] b21,
  output logic [DATA_W-1:0] b22,
  output logic              arr_rst,
  output logic              res_valid,
  output logic              busy,
  output logic              frame_err
);

  mm_state_e                       state_q, state_d;
  logic [3:0]                      run_cnt_q, run_cnt_d;
  logic [MM_ELEMS-1:0][DATA_W-1:0] act_q, act_d;
  logic [MM_ELEMS-1:0][DATA_W-1:0] shadow_data;
  logic                            shadow_full;
  logic                            shadow_clr;
  logic                            arr_rst_q, arr_rst_d;
  logic                            res_valid_q, res_valid_d;
  logic                            busy_q, busy_d;

  mm_operand_shadow #(
    .DATA_W (DATA_W)
  ) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .in_data     (s_if.in_data),
    .in_valid    (s_if.in_valid),
    .in_last     (s_if.in_last),
    .in_ready    (s_if.in_ready),
    .clr         (shadow_clr),
    .full        (shadow_full),
    .frame_err   (frame_err),
    .shadow_data (shadow_data)
  );

  // The shadow is released on the same edge its contents land in act_q
  assign shadow_clr = (state_q == IDLE) && shadow_full;

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    act_d     = act_q;
    case (state_q)
      IDLE: begin
        if (shadow_full) begin
          state_d = LAUNCH;
          act_d   = shadow_data;
        end
      end
      LAUNCH: begin
        state_d   = RUN;
        run_cnt_d = '0;
      end
      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (run_cnt_q == 4'(RUN_CYCLES - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are decoded from the next state so they register alongside it
    arr_rst_d   = (state_d == IDLE) || (state_d == LAUNCH);
    res_valid_d = (state_d == DONE);
    busy_d      = (state_d == LAUNCH) || (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_cnt_q   <= '0;
      act_q       <= '0;
      arr_rst_q   <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      act_q       <= act_d;
      arr_rst_q   <= arr_rst_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign a11       = act_q[IDX_A11];
  assign a12       = act_q[IDX_A12];
  assign a21       = act_q[IDX_A21];
  assign a22       = act_q[IDX_A22];
  assign b11       = act_q[IDX_B11];
  assign b12       = act_q[IDX_B12];
  assign b21       = act_q[IDX_B21];
  assign b22       = act_q[IDX_B22];
  assign arr_rst   = arr_rst_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mm_operand_loader.sv
// Scoreboard bench for mm_operand_loader with a behavioural 2x2 array model
// that forms c = A*B from the loader's operand outputs.
module tb_mm_operand_loader;
  import mm_pkg::*;

  localparam int RC = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] a11, a12, a21, a22, b11, b12, b21, b22;
  logic arr_rst, res_valid, busy, frame_err;

  mm_operand_loader_if #(.DATA_W(8)) sif ();

  mm_operand_loader #(.DATA_W(8), .RUN_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .s_if(sif),
    .a11(a11), .a12(a12), .a21(a21), .a22(a22),
    .b11(b11), .b12(b12), .b21(b21), .b22(b22),
    .arr_rst(arr_rst), .res_valid(res_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream array: 17-bit signed dot products of the active operands
  logic signed [MM_RES_W-1:0] c11, c12, c21, c22;
  always_comb begin
    c11 = $signed(a11) * $signed(b11) + $signed(a12) * $signed(b21);
    c12 = $signed(a11) * $signed(b12) + $signed(a12) * $signed(b22);
    c21 = $signed(a21) * $signed(b11) + $signed(a22) * $signed(b21);
    c22 = $signed(a21) * $signed(b12) + $signed(a22) * $signed(b22);
  end

  typedef struct {
    logic [63:0] ops;
    int          x11, x12, x21, x22;
    int          exp_cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         last_acc_cyc = 0;
  logic [7:0] frm [8];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_frm(input logic [63:0] v);
    for (int i = 0; i < 8; i++) frm[i] = v[8*i +: 8];
  endtask

  task automatic push_exp(input int x11, input int x12, input int x21, input int x22,
                          input int ecyc);
    exp_t e;
    for (int i = 0; i < 8; i++) e.ops[8*i +: 8] = frm[i];
    e.x11 = x11; e.x12 = x12; e.x21 = x21; e.x22 = x22;
    e.exp_cyc = ecyc;
    sb.push_back(e);
  endtask

  // Presents one byte and returns right after the edge that accepts it
  task automatic send_byte(input logic [7:0] d, input logic last);
    int g = 0;
    @(negedge clk);
    sif.in_data = d; sif.in_valid = 1'b1; sif.in_last = last;
    while (!sif.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("ready_timeout", 0, 1);
    last_acc_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    sif.in_valid = 1'b0;
    sif.in_last  = 1'b0;
    @(posedge clk);
  endtask

  // Ends at the negedge after the final accepted byte
  task automatic send_frame(input int nbytes, input int last_at, input bit gaps);
    for (int i = 0; i < nbytes; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle_cycle();
      send_byte(frm[i], i == last_at);
    end
    @(negedge clk);
    sif.in_valid = 1'b0;
    sif.in_last  = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where res_valid is high
  task automatic wait_res();
    int g = 0;
    while (!res_valid && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (g >= 60) check("res_timeout", 0, 1);
  endtask

  task automatic res_end(input string tag);
    @(negedge clk);
    check({tag, "_res_valid_fall"}, res_valid, 0);
    check({tag, "_arr_rst_rise"}, arr_rst, 1);
  endtask

  task automatic no_launch(input string tag, input int n);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!arr_rst || busy) lows++;
    end
    check({tag, "_no_launch"}, lows, 0);
  endtask

  // Monitor: pops one expectation per res_valid strobe
  initial begin
    exp_t e;
    int   low_run = 0;
    int   n_res = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        low_run = 0;
      end else begin
        low_run = arr_rst ? 0 : low_run + 1;
        if (res_valid) begin
          n_res++;
          $display("res %0d @cyc %0d: ops=%h c11=%0d c12=%0d c21=%0d c22=%0d", n_res, cyc,
                   {b22, b21, b12, b11, a22, a21, a12, a11}, c11, c12, c21, c22);
          if (sb.size() == 0) begin
            check("unexpected_res_valid", 1, 0);
          end else begin
            e = sb.pop_front();
            check("ops", {b22, b21, b12, b11, a22, a21, a12, a11}, e.ops);
            check("c11", c11, e.x11);
            check("c12", c12, e.x12);
            check("c21", c21, e.x21);
            check("c22", c22, e.x22);
            check("arr_rst_low_cycles", low_run, RC + 1);
            if (e.exp_cyc >= 0) check("res_latency_cyc", cyc, e.exp_cyc);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.in_data = '0; sif.in_valid = 1'b0; sif.in_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", sif.in_ready, 1);
    check("rst_ops", {b22, b21, b12, b11, a22, a21, a12, a11}, 0);
    check("rst_arr_rst", arr_rst, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;

    // Single frame 1..8
    set_frm(64'h0807060504030201);
    send_frame(8, 7, 0);
    push_exp(19, 22, 43, 50, last_acc_cyc + 3 + RC);
    wait_res();
    res_end("f1");

    // Extremes
    set_frm({8{8'h80}});
    send_frame(8, 7, 0);
    push_exp(32768, 32768, 32768, 32768, last_acc_cyc + 3 + RC);
    wait_res();
    res_end("neg128");
    set_frm({8{8'h7f}});
    send_frame(8, 7, 0);
    push_exp(32258, 32258, 32258, 32258, last_acc_cyc + 3 + RC);
    wait_res();
    res_end("pos127");

    // Back-to-back: second frame streams during the first RUN
    set_frm(64'h0807060504030201);
    send_frame(8, 7, 0);
    push_exp(19, 22, 43, 50, last_acc_cyc + 3 + RC);
    set_frm(64'h0101010102000002);
    send_frame(8, 7, 0);
    push_exp(2, 2, 2, 2, -1);
    check("b2b_ready_low_after_8th", sif.in_ready, 0);
    check("b2b_a11_hold_run", a11, 1);
    wait_res();
    check("b2b_a11_hold_done", a11, 1);
    @(negedge clk);
    check("b2b_a11_hold_idle", a11, 1);
    check("b2b_ready_low_idle", sif.in_ready, 0);
    @(negedge clk);
    check("b2b_a11_launch", a11, 2);
    check("b2b_ready_after_launch", sif.in_ready, 1);
    check("b2b_busy_launch", busy, 1);
    @(negedge clk);
    wait_res();
    res_end("b2b");

    // Framing violation: in_last on the 5th byte
    set_frm(64'h0000000504030201);
    send_frame(5, 4, 0);
    no_launch("frm", 12);
    check("frm_err_set", frame_err, 1);
    check("frm_ready", sif.in_ready, 1);
    set_frm(64'h0807060504030201);
    send_frame(8, 7, 0);
    push_exp(19, 22, 43, 50, last_acc_cyc + 3 + RC);
    wait_res();
    res_end("frm_recover");
    check("frm_err_sticky", frame_err, 1);

    // Reset in RUN cycle 3 with a partial next frame in the shadow
    set_frm(64'h0807060504030201);
    send_frame(8, 7, 0);
    set_frm(64'h000000000000_0B0A09 | 64'h0);
    send_byte(frm[0], 1'b0);
    send_byte(frm[1], 1'b0);
    send_byte(frm[2], 1'b0);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    sif.in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_arr_rst", arr_rst, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_ops", {b22, b21, b12, b11, a22, a21, a12, a11}, 0);
    check("mid_rst_in_ready", sif.in_ready, 1);
    check("mid_rst_frame_err", frame_err, 0);
    rst = 1'b0;
    // Had the 3 bytes survived, these 5 would complete a frame and launch
    set_frm(64'h0000_00100F0E0D0C);
    send_frame(5, 4, 0);
    no_launch("post_rst", 15);
    check("post_rst_partial_dropped", frame_err, 1);

    // Handshake stress with random gaps
    set_frm(64'h0807060504030201);
    send_frame(8, 7, 1);
    push_exp(19, 22, 43, 50, last_acc_cyc + 3 + RC);
    wait_res();
    res_end("stress");

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
